fifo_block_reducer: RTL and testbench
=====================================

// Module: fifo_block_reducer
// PURPOSE
// - Stream consumer downstream of a fifo_user output FIFO: pops words from an upstream fifo,
//   sums each group of BLOCK_LEN words, pushes each block sum into a downstream fifo.
// - Raises sticky valid once NUM_BLOCKS sums are written; same fifo read/write handshake as fifo_user.
// PARAMETERS
// - WIDTH       32  data width of upstream words, accumulator and downstream sum word
// - BLOCK_LEN   4   words per block (>=1)
// - NUM_BLOCKS  2   block sums before valid asserts and the block halts; 0 = run forever
// PORTS
// - clk             input   1      single clock, rising edge
// - rst             input   1      asynchronous, active-low reset (0 = reset)
// - valid           output  1      sticky done: NUM_BLOCKS sums written
// - in_read_valid   output  1      pop request to upstream fifo
// - in_read_ready   input   1      upstream fifo non-empty
// - in_out_data     input   WIDTH  upstream fifo registered read data
// - out_write_valid output  1      push request to downstream fifo
// - out_write_ready input   1      downstream fifo not full
// - out_in_data     output  WIDTH  word pushed downstream (block sum)
// - blocks_done     output  16     count of sums written (wraps mod 2^16)
// BEHAVIOUR
// - Reset (rst=0, async): state=S_ACC, acc=0, issued=0, taken=0, pend=0, blocks_done=0,
//   valid=0; all outputs 0. Reset mid-block drops the partial sum; words already popped are lost.
// - Fifo protocol: pop occurs at an edge where in_read_valid=1; popped word is on in_out_data
//   after that edge and is sampled at the next edge. Push occurs at an edge with out_write_valid=1.
// - in_read_valid = (state==S_ACC) && in_read_ready && (issued < BLOCK_LEN); combinational on
//   in_read_ready; never asserted while upstream empty.
// - out_write_valid = (state==S_WRITE) && out_write_ready; never asserted while downstream full.
// - pend <= in_read_valid each edge; if pend: acc <= acc + in_out_data (mod 2^WIDTH), taken++.
// - Back-to-back: a pop and an accumulate of the previous pop occur at the same edge.
// - S_ACC -> S_WRITE at the edge where taken reaches BLOCK_LEN; out_in_data = acc in S_WRITE.
// - S_WRITE, push edge: blocks_done++, acc=0, issued=0, taken=0; if NUM_BLOCKS!=0 and
//   blocks_done+1==NUM_BLOCKS -> S_DONE else -> S_ACC.
// - S_WRITE with out_write_ready=0: hold acc/out_in_data stable, no pops (back-pressure).
// - S_DONE: valid=1, no pops/pushes, absorbing until reset.
// - Latency (data present, downstream ready): BLOCK_LEN=4 pops at edges 1-4, accumulates at 2-5,
//   push at edge 6; next block's first pop at edge 7.
// - Upstream gaps: issued/taken hold; accumulation resumes on next pop, sum unaffected.
// - Overflow: sum wraps modulo 2^WIDTH; no saturation, no flag.
// STRUCTURE
// - Shared include fifo_reducer_defs.vh: state encodings S_ACC=2'd0, S_WRITE=2'd1,
//   S_DONE=2'd2; blocks_done width constant.
// - One sub-module reducer_acc: WIDTH accumulator + taken counter (clear, add_en, data in,
//   sum/count out). Top holds FSM, issued counter, pend flag, handshake decode.
// TESTING (bench: fifo(DEPTH=16) upstream and downstream, as in fifo_user benches)
// - Reset: rst=0 then 1 -> valid=0, in_read_valid=0, out_write_valid=0, blocks_done=0.
// - Single block: push 1,2,3,4 upstream, run 8 cycles -> downstream holds 10, blocks_done=1, valid=0.
// - Two blocks with gaps: push 5,6 then 2 idle cycles then 7,8,100,200,300,400 -> downstream
//   holds 26 then 1000, valid=1, no further pops (upstream count unchanged).
// - Back-pressure: pre-fill downstream to 16, feed block 1,1,1,1 -> out_write_valid stays 0,
//   out_in_data=4 stable; pop one downstream word -> sum 4 pushed next edge.
// - Wrap: WIDTH=32, words 32'hFFFFFFFF,2,0,0 -> downstream word 32'd1.
// - Reset mid-block: push 9,9, deassert rst after 2 pops, release, push 1,2,3,4 -> sum 10 only.

Source files
------------

// File: rtl/fifo_block_reducer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_block_reducer_pkg
// Shared definitions for the block reducer: FSM state encoding, width of the
// completed-block counter and a helper that sizes the per-block word counters.
// ---------------------------------------------------------------------------
package fifo_block_reducer_pkg;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int BLOCKS_DONE_W = 16;

    // Bits needed to count from 0 up to and including block_len.
    function automatic int cnt_width(input int block_len);
        return $clog2(block_len + 1);
    endfunction

endpackage

// File: rtl/fifo_block_reducer_if.sv
// ---------------------------------------------------------------------------
// fifo_block_reducer_if
// Groups the upstream pop handshake, the downstream push handshake and the
// status outputs of the block reducer.
//   master : the reducer (drives pop/push requests, sum word, status)
//   slave  : the fifo environment (drives fifo status and read data)
// ---------------------------------------------------------------------------
interface fifo_block_reducer_if #(
    parameter int WIDTH = 32
);
    logic                                              valid;
    logic                                              in_read_valid;
    logic                                              in_read_ready;
    logic [WIDTH-1:0]                                  in_out_data;
    logic                                              out_write_valid;
    logic                                              out_write_ready;
    logic [WIDTH-1:0]                                  out_in_data;
    logic [fifo_block_reducer_pkg::BLOCKS_DONE_W-1:0]  blocks_done;

    modport master (
        output valid, in_read_valid, out_write_valid, out_in_data, blocks_done,
        input  in_read_ready, in_out_data, out_write_ready
    );

    modport slave (
        input  valid, in_read_valid, out_write_valid, out_in_data, blocks_done,
        output in_read_ready, in_out_data, out_write_ready
    );
endinterface

// File: rtl/fifo_block_reducer_acc.sv
// ---------------------------------------------------------------------------
// fifo_block_reducer_acc
// Block accumulator: modular sum of the words of one block plus a count of
// the words taken so far. Clear has priority over add.
// Ports: clk, rst (async active-low), clear_i, add_en_i, data_i,
//        sum_o (running sum), count_o (words taken)
// ---------------------------------------------------------------------------
module fifo_block_reducer_acc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             add_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] count_q;

    // Sum and word count registers; sum wraps modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q   <= {WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            sum_q   <= {WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else if (add_en_i) begin
            sum_q   <= sum_q + data_i;
            count_q <= count_q + CNT_W'(1);
        end else begin
            sum_q   <= sum_q;
            count_q <= count_q;
        end
    end

    assign sum_o   = sum_q;
    assign count_o = count_q;
endmodule

// File: rtl/fifo_block_reducer.sv
// ---------------------------------------------------------------------------
// fifo_block_reducer
// Pops words from an upstream fifo, sums each group of BLOCK_LEN words and
// pushes each sum into a downstream fifo. After NUM_BLOCKS sums (0 = never)
// the block halts with sticky valid until reset.
// Ports: clk, rst (async active-low), bus (fifo_block_reducer_if.master)
// ---------------------------------------------------------------------------
module fifo_block_reducer
    import fifo_block_reducer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BLOCK_LEN  = 4,
    parameter int NUM_BLOCKS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_block_reducer_if.master bus
);
    localparam int                       CNT_W       = cnt_width(BLOCK_LEN);
    localparam logic [CNT_W-1:0]         BLK_LEN     = CNT_W'(BLOCK_LEN);
    localparam logic [CNT_W-1:0]         CNT_ONE     = CNT_W'(1);
    localparam logic [BLOCKS_DONE_W-1:0] DONE_ONE    = BLOCKS_DONE_W'(1);
    localparam logic [BLOCKS_DONE_W-1:0] NUM_BLK     = BLOCKS_DONE_W'(NUM_BLOCKS);
    localparam logic                     RUN_FOREVER = (NUM_BLOCKS == 0) ? 1'b1 : 1'b0;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         issued_q;
    logic                     pend_q;
    logic [BLOCKS_DONE_W-1:0] blocks_done_q;
    logic [WIDTH-1:0]         acc_sum_s;
    logic [CNT_W-1:0]         taken_s;
    logic                     rd_en_s;
    logic                     wr_en_s;
    logic                     last_take_s;

    fifo_block_reducer_acc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (wr_en_s),
        .add_en_i (pend_q),
        .data_i   (bus.in_out_data),
        .sum_o    (acc_sum_s),
        .count_o  (taken_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACC: begin
                if (last_take_s) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_WRITE: begin
                if (wr_en_s) begin
                    if (!RUN_FOREVER && ((blocks_done_q + DONE_ONE) == NUM_BLK)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_ACC;
        endcase
    end

    // FSM output decode: fifo handshakes and the block-complete strobe.
    // Pops are gated by rst so nothing is requested while the block is held
    // in reset (a word popped then would be lost).
    always_comb begin
        rd_en_s     = 1'b0;
        wr_en_s     = 1'b0;
        last_take_s = 1'b0;
        case (state_q)
            S_ACC: begin
                rd_en_s     = rst && bus.in_read_ready && (issued_q < BLK_LEN);
                last_take_s = pend_q && (taken_s == (BLK_LEN - CNT_ONE));
            end
            S_WRITE: begin
                wr_en_s = bus.out_write_ready;
            end
            S_DONE: begin
                rd_en_s = 1'b0;
            end
            default: begin
                rd_en_s = 1'b0;
            end
        endcase
    end

    // Issued-pop counter, pending-read flag and completed-block counter.
    // pend marks that the word popped at the previous edge is now on
    // in_out_data and must be accumulated at this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_q      <= {CNT_W{1'b0}};
            pend_q        <= 1'b0;
            blocks_done_q <= {BLOCKS_DONE_W{1'b0}};
        end else begin
            pend_q <= rd_en_s;
            if (wr_en_s) begin
                issued_q      <= {CNT_W{1'b0}};
                blocks_done_q <= blocks_done_q + DONE_ONE;
            end else if (rd_en_s) begin
                issued_q      <= issued_q + CNT_ONE;
                blocks_done_q <= blocks_done_q;
            end else begin
                issued_q      <= issued_q;
                blocks_done_q <= blocks_done_q;
            end
        end
    end

    assign bus.valid           = (state_q == S_DONE);
    assign bus.in_read_valid   = rd_en_s;
    assign bus.out_write_valid = wr_en_s;
    assign bus.out_in_data     = acc_sum_s;
    assign bus.blocks_done     = blocks_done_q;
endmodule

// File: tb/tb_fifo_block_reducer.sv
// ---------------------------------------------------------------------------
// tb_fifo_block_reducer
// Bench for fifo_block_reducer (WIDTH=32, BLOCK_LEN=4, NUM_BLOCKS=2) with a
// 16-deep upstream fifo model and a 16-deep downstream occupancy model.
// Expected sums come from grouping the popped words in fours; a per-cycle
// monitor checks the DUT against that model, and directed literal checks
// pin the model for each scenario.
// ---------------------------------------------------------------------------
module tb_fifo_block_reducer;
    localparam int WIDTH     = 32;
    localparam int DEPTH     = 16;
    localparam int BLOCK_LEN = 4;
    localparam int NUM_BLK   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_block_reducer_if #(.WIDTH(WIDTH)) bus();

    fifo_block_reducer #(
        .WIDTH      (WIDTH),
        .BLOCK_LEN  (BLOCK_LEN),
        .NUM_BLOCKS (NUM_BLK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bench-side stimulus controls
    logic             up_push = 1'b0;
    logic [WIDTH-1:0] up_data = 32'd0;
    logic             dn_push = 1'b0;
    logic             dn_pop  = 1'b0;
    logic             flush   = 1'b0;

    // Upstream fifo model (registered read data)
    logic [WIDTH-1:0] up_mem [DEPTH];
    logic [3:0]       up_wp  = 4'd0;
    logic [3:0]       up_rp  = 4'd0;
    logic [4:0]       up_cnt = 5'd0;
    logic             up_pop_s;
    assign bus.in_read_ready = (up_cnt != 5'd0);
    assign up_pop_s          = bus.in_read_valid && (up_cnt != 5'd0);

    always @(posedge clk) begin
        if (flush) begin
            up_cnt <= 5'd0;
            up_rp  <= up_wp;
        end else begin
            if (up_pop_s) begin
                bus.in_out_data <= up_mem[up_rp];
                up_rp           <= up_rp + 4'd1;
            end
            if (up_push) begin
                up_mem[up_wp] <= up_data;
                up_wp         <= up_wp + 4'd1;
            end
            up_cnt <= up_cnt + (up_push ? 5'd1 : 5'd0) - (up_pop_s ? 5'd1 : 5'd0);
        end
    end

    // Downstream fifo occupancy model (pushed values are logged in got_q)
    logic [4:0] dn_cnt = 5'd0;
    logic       dn_in_s;
    logic       dn_out_s;
    assign bus.out_write_ready = (dn_cnt < 5'd16);
    assign dn_in_s  = dn_push || (bus.out_write_valid && bus.out_write_ready);
    assign dn_out_s = dn_pop && (dn_cnt != 5'd0);

    always @(posedge clk) begin
        if (flush) begin
            dn_cnt <= 5'd0;
        end else begin
            dn_cnt <= dn_cnt + (dn_in_s ? 5'd1 : 5'd0) - (dn_out_s ? 5'd1 : 5'd0);
        end
    end

    // Reference model: every BLOCK_LEN popped words form one expected sum.
    logic [WIDTH-1:0] exp_sums [$];
    logic [WIDTH-1:0] got_q [$];
    logic [WIDTH-1:0] part_sum  = 32'd0;
    int               part_n    = 0;
    int               pop_total = 0;

    always @(posedge clk) begin
        if (!rst) begin
            part_n   <= 0;
            part_sum <= 32'd0;
            exp_sums.delete();
            got_q.delete();
        end else begin
            if (up_pop_s) begin
                pop_total <= pop_total + 1;
                if (part_n == BLOCK_LEN - 1) begin
                    exp_sums.push_back(part_sum + up_mem[up_rp]);
                    part_n   <= 0;
                    part_sum <= 32'd0;
                end else begin
                    part_n   <= part_n + 1;
                    part_sum <= part_sum + up_mem[up_rp];
                end
            end
            if (bus.out_write_valid && bus.out_write_ready) begin
                got_q.push_back(bus.out_in_data);
            end
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        else return 32'hDEADBEEF;
    endfunction

    // Per-cycle comparison against the model.
    task automatic cycle_check();
        int n;
        n = got_q.size();
        if (!rst) begin
            chk("rst_valid", {31'd0, bus.valid}, 32'd0);
            chk("rst_in_read_valid", {31'd0, bus.in_read_valid}, 32'd0);
            chk("rst_out_write_valid", {31'd0, bus.out_write_valid}, 32'd0);
            chk("rst_blocks_done", {16'd0, bus.blocks_done}, 32'd0);
            chk("rst_out_in_data", bus.out_in_data, 32'd0);
        end else begin
            chk("blocks_done", {16'd0, bus.blocks_done}, 32'(n));
            chk("valid", {31'd0, bus.valid}, (n >= NUM_BLK) ? 32'd1 : 32'd0);
            if (bus.out_write_valid) begin
                chk("push_while_full", (dn_cnt < 5'd16) ? 32'd1 : 32'd0, 32'd1);
                chk("push_has_block", (exp_sums.size() > n) ? 32'd1 : 32'd0, 32'd1);
                if (exp_sums.size() > n) begin
                    chk("block_sum", bus.out_in_data, exp_sums[n]);
                end
            end
            if (bus.in_read_valid) begin
                chk("pop_while_empty", (up_cnt != 5'd0) ? 32'd1 : 32'd0, 32'd1);
                chk("pop_after_done", (n < NUM_BLK) ? 32'd1 : 32'd0, 32'd1);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic up_write(input logic [31:0] d);
        up_push = 1'b1;
        up_data = d;
        @(negedge clk);
        up_push = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        flush = 1'b1;
        cycles(2);
        flush = 1'b0;
        rst   = 1'b1;
    endtask

    initial begin
        int base;
        bit seen;
        fork
            forever begin
                @(negedge clk);
                #1;
                cycle_check();
            end
        join_none

        // Reset state
        flush = 1'b1;
        cycles(3);
        chk("reset_valid", {31'd0, bus.valid}, 32'd0);
        chk("reset_in_read_valid", {31'd0, bus.in_read_valid}, 32'd0);
        chk("reset_out_write_valid", {31'd0, bus.out_write_valid}, 32'd0);
        chk("reset_blocks_done", {16'd0, bus.blocks_done}, 32'd0);
        flush = 1'b0;
        rst   = 1'b1;
        cycles(1);
        chk("idle_in_read_valid", {31'd0, bus.in_read_valid}, 32'd0);
        chk("idle_valid", {31'd0, bus.valid}, 32'd0);

        // Single block 1+2+3+4
        up_write(32'd1); up_write(32'd2); up_write(32'd3); up_write(32'd4);
        cycles(8);
        chk("single_count", 32'(got_q.size()), 32'd1);
        chk("single_sum", got_at(0), 32'd10);
        chk("single_blocks_done", {16'd0, bus.blocks_done}, 32'd1);
        chk("single_valid", {31'd0, bus.valid}, 32'd0);

        // Two blocks with an upstream gap, then halt
        do_reset();
        up_write(32'd5); up_write(32'd6);
        cycles(2);
        up_write(32'd7); up_write(32'd8); up_write(32'd100);
        up_write(32'd200); up_write(32'd300); up_write(32'd400);
        cycles(12);
        chk("two_count", 32'(got_q.size()), 32'd2);
        chk("two_sum0", got_at(0), 32'd26);
        chk("two_sum1", got_at(1), 32'd1000);
        chk("two_valid", {31'd0, bus.valid}, 32'd1);
        chk("two_blocks_done", {16'd0, bus.blocks_done}, 32'd2);
        up_write(32'd11); up_write(32'd12); up_write(32'd13);
        cycles(6);
        chk("done_no_pops", {27'd0, up_cnt}, 32'd3);
        chk("done_valid_sticky", {31'd0, bus.valid}, 32'd1);

        // Back-pressure: downstream full
        do_reset();
        dn_push = 1'b1;
        cycles(16);
        dn_push = 1'b0;
        chk("prefill_count", {27'd0, dn_cnt}, 32'd16);
        up_write(32'd1); up_write(32'd1); up_write(32'd1); up_write(32'd1);
        cycles(10);
        chk("bp_no_push", {31'd0, bus.out_write_valid}, 32'd0);
        chk("bp_data", bus.out_in_data, 32'd4);
        cycles(3);
        chk("bp_data_stable", bus.out_in_data, 32'd4);
        chk("bp_blocks_done", {16'd0, bus.blocks_done}, 32'd0);
        dn_pop = 1'b1;
        @(negedge clk);
        dn_pop = 1'b0;
        chk("bp_release_push", {31'd0, bus.out_write_valid}, 32'd1);
        cycles(1);
        chk("bp_sum", got_at(0), 32'd4);
        chk("bp_after_blocks_done", {16'd0, bus.blocks_done}, 32'd1);
        chk("bp_dn_full_again", {27'd0, dn_cnt}, 32'd16);

        // Wrap modulo 2^32
        do_reset();
        up_write(32'hFFFFFFFF); up_write(32'd2); up_write(32'd0); up_write(32'd0);
        cycles(8);
        chk("wrap_sum", got_at(0), 32'd1);
        chk("wrap_blocks_done", {16'd0, bus.blocks_done}, 32'd1);

        // Reset in the middle of a block
        do_reset();
        base = pop_total;
        up_write(32'd9); up_write(32'd9);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen && (pop_total >= base + 2)) seen = 1'b1;
            if (!seen) @(negedge clk);
        end
        chk("midrst_two_pops", {31'd0, seen}, 32'd1);
        do_reset();
        up_write(32'd1); up_write(32'd2); up_write(32'd3); up_write(32'd4);
        cycles(10);
        chk("midrst_count", 32'(got_q.size()), 32'd1);
        chk("midrst_sum", got_at(0), 32'd10);
        chk("midrst_blocks_done", {16'd0, bus.blocks_done}, 32'd1);
        chk("midrst_valid", {31'd0, bus.valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
